commit_tab_ctrl: RTL and testbench

- In-order issue-number allocator and commit tracker for the scalar unit's Hazard Check Table.
- Allocates an issue_no to each instruction leaving the hazard-check stage and records out-of-order completion reports from the execution pipes.
- Retires entries strictly in issue order and emits one retire pulse per entry, so the hazard table can clear the matching slot.
- Sits between the hazard-check stage (issue side), the execution-stage write-back (commit side) and the hazard table (retire side).

---
 rtl/commit_tab_ctrl.sv | 128 ++++++++++++
 tb/tb_commit_tab_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_tab_ctrl.sv
// In-order issue-number allocator and out-of-order commit tracker for the hazard check table.
// Optional per-lane commit tracking is enabled by defining TPU_VECTOR_COMMIT_EN.
module commit_tab_ctrl #(
    parameter int NUM_ENTRY = 8,
    parameter int WIDTH_NO  = $clog2(NUM_ENTRY),
    parameter int NUM_LANE  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                I_Req_Issue,
    output logic                O_Ack_Issue,
    output logic [WIDTH_NO-1:0] O_Issue_No,
    input  logic                I_Commit,
    input  logic [WIDTH_NO-1:0] I_Commit_No,
`ifdef TPU_VECTOR_COMMIT_EN
    input  logic [NUM_LANE-1:0] I_En_Lane,
    input  logic [NUM_LANE-1:0] I_Commit_Lane,
`endif
    output logic                O_Retire,
    output logic [WIDTH_NO-1:0] O_Retire_No,
    output logic                O_Full,
    output logic                O_Empty,
    output logic [WIDTH_NO:0]   O_Count,
    output logic                O_Error
);

    logic [NUM_ENTRY-1:0] ent_v;
    logic [NUM_ENTRY-1:0] ent_cm;
    logic [WIDTH_NO-1:0]  head_q;
    logic [WIDTH_NO-1:0]  tail_q;
    logic [WIDTH_NO:0]    count_q;
    logic                 retire_q;
    logic [WIDTH_NO-1:0]  retire_no_q;
    logic                 error_q;

    logic issue_acc;
    logic head_ret;
    logic commit_hit;
    logic commit_ok;
    logic commit_done;

`ifdef TPU_VECTOR_COMMIT_EN
    logic [NUM_ENTRY-1:0][NUM_LANE-1:0] en_lane_q;
    logic [NUM_ENTRY-1:0][NUM_LANE-1:0] en_commit_q;
    logic                               lane_bad;
`endif

    assign O_Full      = (count_q == (WIDTH_NO+1)'(NUM_ENTRY));
    assign O_Empty     = (count_q == '0);
    assign O_Count     = count_q;
    assign O_Ack_Issue = I_Req_Issue & ~O_Full;
    assign O_Issue_No  = tail_q;
    assign O_Retire    = retire_q;
    assign O_Retire_No = retire_no_q;
    assign O_Error     = error_q;

    assign issue_acc = O_Ack_Issue;
    assign head_ret  = ent_v[head_q] & ent_cm[head_q];

    // A commit to the slot being allocated this cycle is treated as naming a dead entry.
    assign commit_hit = ent_v[I_Commit_No] & ~ent_cm[I_Commit_No]
                      & ~(issue_acc & (I_Commit_No == tail_q));

`ifdef TPU_VECTOR_COMMIT_EN
    // Reporting lanes must be enabled and must not have reported before.
    assign lane_bad    = |(I_Commit_Lane & ~en_lane_q[I_Commit_No])
                       | |(I_Commit_Lane & en_commit_q[I_Commit_No]);
    assign commit_ok   = commit_hit & ~lane_bad;
    assign commit_done = (((en_commit_q[I_Commit_No] | I_Commit_Lane) & en_lane_q[I_Commit_No])
                          == en_lane_q[I_Commit_No]);
`else
    assign commit_ok   = commit_hit;
    assign commit_done = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_v       <= '0;
            ent_cm      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            retire_q    <= 1'b0;
            retire_no_q <= '0;
            error_q     <= 1'b0;
`ifdef TPU_VECTOR_COMMIT_EN
            en_lane_q   <= '0;
            en_commit_q <= '0;
`endif
        end else begin
            retire_q <= head_ret;
            count_q  <= count_q + (WIDTH_NO+1)'(issue_acc) - (WIDTH_NO+1)'(head_ret);

            if (head_ret) begin
                ent_v[head_q]  <= 1'b0;
                ent_cm[head_q] <= 1'b0;
                retire_no_q    <= head_q;
                head_q         <= head_q + 1'b1;
            end

            // head and tail only coincide when full or empty, so retire and issue never collide.
            if (issue_acc) begin
                ent_v[tail_q] <= 1'b1;
`ifdef TPU_VECTOR_COMMIT_EN
                ent_cm[tail_q]      <= (I_En_Lane == '0);
                en_lane_q[tail_q]   <= I_En_Lane;
                en_commit_q[tail_q] <= '0;
`else
                ent_cm[tail_q] <= 1'b0;
`endif
                tail_q <= tail_q + 1'b1;
            end

            if (I_Commit) begin
                if (commit_ok) begin
`ifdef TPU_VECTOR_COMMIT_EN
                    en_commit_q[I_Commit_No] <= en_commit_q[I_Commit_No] | I_Commit_Lane;
`endif
                    if (commit_done)
                        ent_cm[I_Commit_No] <= 1'b1;
                end else begin
                    error_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_tab_ctrl.sv
// Directed self-checking bench for commit_tab_ctrl; exercises the lane-commit path when
// TPU_VECTOR_COMMIT_EN is defined.
module tb_commit_tab_ctrl;

    localparam int NE = 8;
    localparam int WN = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          I_Req_Issue;
    logic          O_Ack_Issue;
    logic [WN-1:0] O_Issue_No;
    logic          I_Commit;
    logic [WN-1:0] I_Commit_No;
`ifdef TPU_VECTOR_COMMIT_EN
    logic [3:0]    I_En_Lane;
    logic [3:0]    I_Commit_Lane;
`endif
    logic          O_Retire;
    logic [WN-1:0] O_Retire_No;
    logic          O_Full;
    logic          O_Empty;
    logic [WN:0]   O_Count;
    logic          O_Error;

    int n_chk = 0;
    int n_err = 0;

    commit_tab_ctrl #(.NUM_ENTRY(NE), .WIDTH_NO(WN), .NUM_LANE(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .I_Req_Issue (I_Req_Issue),
        .O_Ack_Issue (O_Ack_Issue),
        .O_Issue_No  (O_Issue_No),
        .I_Commit    (I_Commit),
        .I_Commit_No (I_Commit_No),
`ifdef TPU_VECTOR_COMMIT_EN
        .I_En_Lane   (I_En_Lane),
        .I_Commit_Lane(I_Commit_Lane),
`endif
        .O_Retire    (O_Retire),
        .O_Retire_No (O_Retire_No),
        .O_Full      (O_Full),
        .O_Empty     (O_Empty),
        .O_Count     (O_Count),
        .O_Error     (O_Error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        I_Req_Issue = 1'b0;
        I_Commit = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        I_Req_Issue = 1'b0;
        I_Commit = 1'b0;
        I_Commit_No = '0;
`ifdef TPU_VECTOR_COMMIT_EN
        I_En_Lane = 4'b0000;
        I_Commit_Lane = 4'b0000;
`endif
        do_reset();
        #1;
        chk("rst_empty", O_Empty, 1);
        chk("rst_full", O_Full, 0);
        chk("rst_count", O_Count, 0);
        chk("rst_ack", O_Ack_Issue, 0);
        chk("rst_retire", O_Retire, 0);
        chk("rst_error", O_Error, 0);

        // Fill the table: issue numbers 0..7.
        I_Req_Issue = 1'b1;
        for (int i = 0; i < NE; i++) begin
            #1;
            chk("fill_ack", O_Ack_Issue, 1);
            chk("fill_no", O_Issue_No, i);
            tick();
        end
        chk("fill_count", O_Count, 8);
        chk("fill_full", O_Full, 1);
        chk("fill_ack9", O_Ack_Issue, 0);

        // Full table with head committed: retire frees a slot but issue waits one cycle.
        I_Req_Issue = 1'b0;
        I_Commit = 1'b1; I_Commit_No = 3'd0;
        tick();
        chk("fw_no_ret", O_Retire, 0);
        I_Commit = 1'b0; I_Req_Issue = 1'b1;
        #1;
        chk("fw_ack_blk", O_Ack_Issue, 0);
        tick();
        chk("fw_ret", O_Retire, 1);
        chk("fw_ret_no", O_Retire_No, 0);
        chk("fw_count7", O_Count, 7);
        chk("fw_ack", O_Ack_Issue, 1);
        chk("fw_wrap_no", O_Issue_No, 0);
        tick();
        chk("fw_count8", O_Count, 8);
        chk("fw_ret_off", O_Retire, 0);
        chk("fw_err", O_Error, 0);

        // Out-of-order commit, in-order retire.
        do_reset();
        I_Req_Issue = 1'b1;
        tick(); tick(); tick();
        I_Req_Issue = 1'b0;
        chk("ooo_count", O_Count, 3);
        I_Commit = 1'b1;
        I_Commit_No = 3'd2; tick(); chk("ooo_c2", O_Retire, 0);
        I_Commit_No = 3'd1; tick(); chk("ooo_c1", O_Retire, 0);
        I_Commit_No = 3'd0; tick(); chk("ooo_c0", O_Retire, 0);
        I_Commit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ooo_ret", O_Retire, 1);
            chk("ooo_ret_no", O_Retire_No, i);
        end
        chk("ooo_empty", O_Empty, 1);
        chk("ooo_count0", O_Count, 0);
        tick();
        chk("ooo_ret_end", O_Retire, 0);
        chk("ooo_err", O_Error, 0);

        // Commit to a dead entry while empty: sticky error, state unchanged.
        I_Commit = 1'b1; I_Commit_No = 3'd5;
        tick();
        I_Commit = 1'b0;
        chk("dead_err", O_Error, 1);
        chk("dead_empty", O_Empty, 1);
        tick();
        chk("dead_sticky", O_Error, 1);
        chk("dead_ret", O_Retire, 0);

        // Duplicate commit to an already-committed entry.
        do_reset();
        I_Req_Issue = 1'b1;
        tick(); tick();
        I_Req_Issue = 1'b0;
        I_Commit = 1'b1; I_Commit_No = 3'd1;
        tick();
        chk("dup_first", O_Error, 0);
        tick();
        I_Commit = 1'b0;
        chk("dup_err", O_Error, 1);
        chk("dup_count", O_Count, 2);
        chk("dup_ret", O_Retire, 0);

        // Reset mid-operation with 4 live entries and a commit pending.
        I_Req_Issue = 1'b1;
        tick(); tick();
        I_Req_Issue = 1'b0;
        chk("mid_count4", O_Count, 4);
        I_Commit = 1'b1; I_Commit_No = 3'd0; reset = 1'b1;
        tick();
        reset = 1'b0; I_Commit = 1'b0;
        chk("mid_count0", O_Count, 0);
        chk("mid_ret", O_Retire, 0);
        chk("mid_err", O_Error, 0);
        chk("mid_empty", O_Empty, 1);
        I_Req_Issue = 1'b1;
        #1;
        chk("mid_ack", O_Ack_Issue, 1);
        chk("mid_no", O_Issue_No, 0);
        tick();
        chk("mid_count1", O_Count, 1);

        // Commit naming the slot being allocated this same cycle is an error.
        I_Commit = 1'b1; I_Commit_No = 3'd1;
        tick();
        I_Req_Issue = 1'b0; I_Commit = 1'b0;
        chk("clash_err", O_Error, 1);
        chk("clash_count", O_Count, 2);
        tick();
        chk("clash_no_ret", O_Retire, 0);

`ifdef TPU_VECTOR_COMMIT_EN
        // Lane mask 0101: retire only after lanes 0 and 2 have both reported.
        do_reset();
        I_Req_Issue = 1'b1; I_En_Lane = 4'b0101;
        tick();
        I_Req_Issue = 1'b0;
        I_Commit = 1'b1; I_Commit_No = 3'd0; I_Commit_Lane = 4'b0001;
        tick();
        chk("vec_l0_ret", O_Retire, 0);
        I_Commit_Lane = 4'b0100;
        tick();
        I_Commit = 1'b0;
        chk("vec_l2_ret", O_Retire, 0);
        tick();
        chk("vec_ret", O_Retire, 1);
        chk("vec_ret_no", O_Retire_No, 0);
        chk("vec_err0", O_Error, 0);
        // An empty lane mask completes on issue.
        I_Req_Issue = 1'b1; I_En_Lane = 4'b0000;
        tick();
        I_Req_Issue = 1'b0;
        tick();
        chk("vec_zero_ret", O_Retire, 1);
        chk("vec_zero_no", O_Retire_No, 1);
        // Disabled lane reporting.
        I_Req_Issue = 1'b1; I_En_Lane = 4'b0101;
        tick();
        I_Req_Issue = 1'b0;
        I_Commit = 1'b1; I_Commit_No = 3'd2; I_Commit_Lane = 4'b0010;
        tick();
        I_Commit = 1'b0;
        chk("vec_lane_err", O_Error, 1);
        chk("vec_lane_cnt", O_Count, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
